// File: rtl/reg_file_bist.sv
// reg_file_bist: built-in self-test initiator for the MIPS register file.
// Writes PAT^i into every register, reads all registers back through both
// read ports (port 2 walks the addresses in reverse) and reports the
// pass/fail result, a saturating mismatch count and the first failing address.
module reg_file_bist #(
   parameter int              AW      = 5,
   parameter int              DW      = 32,
   parameter logic [DW-1:0]   PAT     = 32'hA5A5A5A5,
   parameter bit              R0_ZERO = 1'b1
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          Start,
   output logic          Busy,
   output logic          Done,
   output logic          Pass,
   output logic [6:0]    ErrCnt,
   output logic [AW-1:0] FirstErrAddr,
   output logic [AW-1:0] Awr,
   output logic [DW-1:0] Din,
   output logic          WrEn,
   output logic [AW-1:0] Ard1,
   output logic [AW-1:0] Ard2,
   input  logic [DW-1:0] Dout1,
   input  logic [DW-1:0] Dout2
);

   localparam logic [1:0] st_idle  = 2'd0;
   localparam logic [1:0] st_write = 2'd1;
   localparam logic [1:0] st_read  = 2'd2;
   localparam logic [1:0] st_done  = 2'd3;

   localparam logic [AW-1:0] zero_addr = {AW{1'b0}};
   localparam logic [AW-1:0] one_addr  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] last_addr = {AW{1'b1}};

   // Value a healthy register file returns for address a.
   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
      logic [DW-1:0] d;
      if (R0_ZERO && (a == zero_addr)) begin
         d = {DW{1'b0}};
      end else begin
         d = PAT ^ DW'(a);
      end
      return d;
   endfunction

   logic [1:0]    state_r;
   logic [1:0]    state_nx_s;
   logic [AW-1:0] addr_r;
   logic [AW-1:0] addr_nx_s;
   logic [AW-1:0] addr2_s;
   logic          miss1_s;
   logic          miss2_s;
   logic [7:0]    err_sum_s;
   logic [6:0]    err_nx_s;
   logic [AW-1:0] first_nx_s;

   // With NREGS = 2**AW, NREGS-1-addr is simply the bitwise inverse.
   assign addr2_s = ~addr_r;

   // Next-state and address counter sequencing.
   always_comb begin
      state_nx_s = state_r;
      addr_nx_s  = addr_r;
      case (state_r)
         st_idle: begin
            if (Start) begin
               state_nx_s = st_write;
               addr_nx_s  = zero_addr;
            end else begin
               state_nx_s = st_idle;
               addr_nx_s  = zero_addr;
            end
         end
         st_write: begin
            if (addr_r == last_addr) begin
               state_nx_s = st_read;
               addr_nx_s  = zero_addr;
            end else begin
               addr_nx_s  = addr_r + one_addr;
            end
         end
         st_read: begin
            if (addr_r == last_addr) begin
               state_nx_s = st_done;
               addr_nx_s  = zero_addr;
            end else begin
               addr_nx_s  = addr_r + one_addr;
            end
         end
         st_done: begin
            state_nx_s = st_idle;
            addr_nx_s  = zero_addr;
         end
         default: begin
            state_nx_s = st_idle;
            addr_nx_s  = zero_addr;
         end
      endcase
   end

   // Read-back comparison and saturating error accumulation.
   always_comb begin
      miss1_s   = (Dout1 != exp_data(addr_r));
      miss2_s   = (Dout2 != exp_data(addr2_s));
      err_sum_s = {1'b0, ErrCnt} + {7'd0, miss1_s} + {7'd0, miss2_s};
      if (err_sum_s > 8'd127) begin
         err_nx_s = 7'd127;
      end else begin
         err_nx_s = err_sum_s[6:0];
      end
      // Port 1 takes priority when both ports miss in the same cycle.
      if (miss1_s) begin
         first_nx_s = addr_r;
      end else begin
         first_nx_s = addr2_s;
      end
   end

   // FSM state and address counter registers.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r <= st_idle;
         addr_r  <= zero_addr;
      end else begin
         state_r <= state_nx_s;
         addr_r  <= addr_nx_s;
      end
   end

   // Register-file drive outputs, registered from the upcoming state.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         WrEn <= 1'b0;
         Busy <= 1'b0;
         Awr  <= zero_addr;
         Din  <= {DW{1'b0}};
         Ard1 <= zero_addr;
         Ard2 <= zero_addr;
         Done <= 1'b0;
      end else begin
         WrEn <= (state_nx_s == st_write);
         Busy <= (state_nx_s == st_write) || (state_nx_s == st_read);
         Awr  <= (state_nx_s == st_write) ? addr_nx_s : zero_addr;
         Din  <= (state_nx_s == st_write) ? (PAT ^ DW'(addr_nx_s)) : {DW{1'b0}};
         Ard1 <= (state_nx_s == st_read) ? addr_nx_s : zero_addr;
         Ard2 <= (state_nx_s == st_read) ? ~addr_nx_s : zero_addr;
         Done <= (state_r == st_done);
      end
   end

   // Test result registers: cleared on Start, updated in READ and DONE, held otherwise.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         Pass         <= 1'b0;
         ErrCnt       <= 7'd0;
         FirstErrAddr <= zero_addr;
      end else if ((state_r == st_idle) && Start) begin
         Pass         <= 1'b0;
         ErrCnt       <= 7'd0;
         FirstErrAddr <= zero_addr;
      end else if (state_r == st_read) begin
         ErrCnt <= err_nx_s;
         // A zero count means no mismatch has been seen yet this run.
         if ((ErrCnt == 7'd0) && (miss1_s || miss2_s)) begin
            FirstErrAddr <= first_nx_s;
         end
      end else if (state_r == st_done) begin
         Pass <= (ErrCnt == 7'd0);
      end
   end

endmodule

// File: tb/tb_reg_file_bist.sv
// tb_reg_file_bist: directed test of reg_file_bist against a behavioural
// register file with selectable faults (none, reg 7 bit 0 stuck-at-1, reads all zero).
module tb_reg_file_bist;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Start;
   logic        Busy;
   logic        Done;
   logic        Pass;
   logic [6:0]  ErrCnt;
   logic [4:0]  FirstErrAddr;
   logic [4:0]  Awr;
   logic [31:0] Din;
   logic        WrEn;
   logic [4:0]  Ard1;
   logic [4:0]  Ard2;
   logic [31:0] Dout1;
   logic [31:0] Dout2;

   int checks = 0;
   int errors = 0;
   int mode   = 0;
   int e;
   int n_done;

   logic [31:0] mem [0:31];

   reg_file_bist dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Busy(Busy), .Done(Done), .Pass(Pass),
      .ErrCnt(ErrCnt), .FirstErrAddr(FirstErrAddr), .Awr(Awr), .Din(Din), .WrEn(WrEn),
      .Ard1(Ard1), .Ard2(Ard2), .Dout1(Dout1), .Dout2(Dout2)
   );

   always #5 Clk = ~Clk;

   // Register file model: reg 0 reads zero, writes on the rising edge.
   always @(posedge Clk) begin
      if (WrEn && (Awr != 5'd0)) mem[Awr] <= Din;
   end

   // Combinational read ports with the selected fault injected.
   always_comb begin
      Dout1 = (Ard1 == 5'd0) ? 32'd0 : mem[Ard1];
      Dout2 = (Ard2 == 5'd0) ? 32'd0 : mem[Ard2];
      if (mode == 1 && Ard1 == 5'd7) Dout1[0] = 1'b1;
      if (mode == 1 && Ard2 == 5'd7) Dout2[0] = 1'b1;
      if (mode == 2) begin
         Dout1 = 32'd0;
         Dout2 = 32'd0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One-cycle Start pulse sampled at the next edge (edge 0 of the run).
   task automatic start_run();
      Start = 1'b1;
      @(posedge Clk);
      #1;
      Start = 1'b0;
   endtask

   // Step edges until Done is seen (bounded); optional Start pulses at edges p1/p2.
   task automatic run_wait(input int p1, input int p2, input bit hold, output int cnt);
      cnt = 0;
      while (Done !== 1'b1 && cnt < 200) begin
         Start = hold | (cnt + 1 == p1) | (cnt + 1 == p2);
         @(posedge Clk);
         cnt++;
         #1;
      end
      Start = hold;
   endtask

   initial begin
      Rst   = 1'b1;
      Start = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_pass", 32'(Pass), 32'd0);
      check("rst_errcnt", 32'(ErrCnt), 32'd0);
      check("rst_wren", 32'(WrEn), 32'd0);
      check("rst_din", Din, 32'd0);
      Rst = 1'b0;
      @(posedge Clk);
      #1;

      // Scenario 1: healthy file, detailed write/read sequencing.
      start_run();
      for (int i = 0; i < 32; i++) begin
         check("s1_wren", 32'(WrEn), 32'd1);
         check("s1_awr", 32'(Awr), 32'(i));
         check("s1_din", Din, 32'hA5A5A5A5 ^ 32'(i));
         check("s1_busy_wr", 32'(Busy), 32'd1);
         @(posedge Clk);
         #1;
      end
      check("s1_wren_off", 32'(WrEn), 32'd0);
      check("s1_busy_rd", 32'(Busy), 32'd1);
      check("s1_ard1_0", 32'(Ard1), 32'd0);
      check("s1_ard2_0", 32'(Ard2), 32'd31);
      @(posedge Clk);
      #1;
      check("s1_ard1_1", 32'(Ard1), 32'd1);
      check("s1_ard2_1", 32'(Ard2), 32'd30);
      run_wait(-1, -1, 1'b0, e);
      check("s1_done_edge", 32'(e + 33), 32'd65);
      check("s1_pass", 32'(Pass), 32'd1);
      check("s1_errcnt", 32'(ErrCnt), 32'd0);
      check("s1_firsterr", 32'(FirstErrAddr), 32'd0);
      check("s1_busy_done", 32'(Busy), 32'd0);
      @(posedge Clk);
      #1;
      check("s1_done_pulse", 32'(Done), 32'd0);
      check("s1_pass_hold", 32'(Pass), 32'd1);

      // Scenario 2: reg 7 bit 0 stuck-at-1, seen by port 1 (addr 7) and port 2 (addr 24).
      mode = 1;
      start_run();
      run_wait(-1, -1, 1'b0, e);
      check("s2_done_edge", 32'(e), 32'd65);
      check("s2_errcnt", 32'(ErrCnt), 32'd2);
      check("s2_firsterr", 32'(FirstErrAddr), 32'd7);
      check("s2_pass", 32'(Pass), 32'd0);
      @(posedge Clk);
      #1;

      // Scenario 6: healthy run straight after the faulty one clears the results.
      mode = 0;
      start_run();
      check("s6_errcnt_clr", 32'(ErrCnt), 32'd0);
      check("s6_firsterr_clr", 32'(FirstErrAddr), 32'd0);
      check("s6_busy", 32'(Busy), 32'd1);
      run_wait(-1, -1, 1'b0, e);
      check("s6_done_edge", 32'(e), 32'd65);
      check("s6_pass", 32'(Pass), 32'd1);
      check("s6_errcnt", 32'(ErrCnt), 32'd0);

      // Scenario 3: reads always zero. Reg 0 matches; 31 regs fail on both ports.
      // In the first read cycle port 1 reads reg 0 (match) while port 2 reads
      // reg 31 (mismatch), so 31 is the first mismatching address.
      mode = 2;
      start_run();
      run_wait(-1, -1, 1'b0, e);
      check("s3_done_edge", 32'(e), 32'd65);
      check("s3_errcnt", 32'(ErrCnt), 32'd62);
      check("s3_firsterr", 32'(FirstErrAddr), 32'd31);
      check("s3_pass", 32'(Pass), 32'd0);

      // Scenario 4: extra Start pulses at edges 5 and 40 are ignored.
      mode = 0;
      start_run();
      run_wait(5, 40, 1'b0, e);
      check("s4_done_edge", 32'(e), 32'd65);
      check("s4_pass", 32'(Pass), 32'd1);
      check("s4_errcnt", 32'(ErrCnt), 32'd0);
      n_done = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge Clk);
         #1;
         if (Done) n_done++;
      end
      check("s4_no_second_done", 32'(n_done), 32'd0);
      check("s4_idle_busy", 32'(Busy), 32'd0);

      // Scenario 5: reset at edge 10 of the write phase aborts the run.
      start_run();
      repeat (9) @(posedge Clk);
      #1;
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      check("s5_wren", 32'(WrEn), 32'd0);
      check("s5_busy", 32'(Busy), 32'd0);
      check("s5_awr", 32'(Awr), 32'd0);
      check("s5_din", Din, 32'd0);
      check("s5_pass", 32'(Pass), 32'd0);
      n_done = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge Clk);
         #1;
         if (Done) n_done++;
      end
      check("s5_no_done", 32'(n_done), 32'd0);
      start_run();
      run_wait(-1, -1, 1'b0, e);
      check("s5_rerun_edge", 32'(e), 32'd65);
      check("s5_rerun_pass", 32'(Pass), 32'd1);

      // Start held high: a new run begins at the first IDLE edge after DONE.
      @(posedge Clk);
      #1;
      Start = 1'b1;
      @(posedge Clk);
      #1;
      run_wait(-1, -1, 1'b1, e);
      check("hold_done_edge", 32'(e), 32'd65);
      @(posedge Clk);
      #1;
      check("hold_restart_busy", 32'(Busy), 32'd1);
      check("hold_restart_wren", 32'(WrEn), 32'd1);
      check("hold_restart_pass", 32'(Pass), 32'd0);
      Start = 1'b0;
      run_wait(-1, -1, 1'b0, e);
      check("hold_second_edge", 32'(e), 32'd65);
      check("hold_second_pass", 32'(Pass), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
